// File: rtl/trivium_feeder.sv
// Host-side driver for the Trivium core: serial key load, credit-metered plaintext
// strobes, ciphertext return FIFO and 256-byte block boundary handling.
//
//   state      | meaning
//   S_IDLE     | no key loaded, waiting for key_load
//   S_SHIFT    | 80 cycles of serial key shift, MSB first
//   S_WAIT_RUN | waiting for core status 01 after keying
//   S_RUN      | issuing plaintext bytes under credit control
//   S_WAIT_BLK | 256 bytes issued, waiting for status 02 then 01
module trivium_feeder #(
    parameter int DEPTH    = 8,
    parameter int WAIT_MAX = 2047
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [79:0] key_in_i,
    input  logic        key_load_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        key_o,
    output logic        strob_key_o,
    output logic [7:0]  data_o,
    output logic        strob_data_o,
    output logic [1:0]  fifo_cnd_o,
    input  logic [7:0]  stream_i,
    input  logic        wt_sgn_i,
    input  logic [7:0]  sign_reg_i,
    output logic        busy_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT_RUN, S_RUN, S_WAIT_BLK} state_t;

    state_t         state_q;
    logic [79:0]    key_sh_q;
    logic [6:0]     bit_cnt_q;
    logic [11:0]    timer_q;
    logic [8:0]     blk_cnt_q;
    logic [CW-1:0]  out_q, out_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]     mem_q [DEPTH];
    logic           rekey_q, seen02_q, err_q;
    logic           key_q, strob_key_q, strob_data_q;
    logic [7:0]     data_q;
    logic [1:0]     fifo_cnd_q;

    logic fifo_full, push, pop, issue, core_fault, out_dec;

    assign fifo_full  = (occ_q == CW'(DEPTH));
    assign push       = wt_sgn_i && !fifo_full;
    assign pop        = rx_ready_i && (occ_q != '0);
    assign core_fault = (state_q != S_IDLE) && ((sign_reg_i == 8'h04) || (sign_reg_i == 8'h08));
    assign out_dec    = wt_sgn_i && (out_q != '0);

    // Credit rule: bytes in flight plus bytes already buffered never exceed the FIFO.
    assign issue = (state_q == S_RUN) && !rekey_q && tx_valid_i && (sign_reg_i == 8'h01)
                   && !blk_cnt_q[8]
                   && (({1'b0, occ_q} + {1'b0, out_q}) < (CW+1)'(DEPTH));

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + CW'(1);
        else if (!push && pop)
            occ_d = occ_q - CW'(1);
    end

    always_comb begin
        out_d = out_q;
        if (issue && !out_dec)
            out_d = out_q + CW'(1);
        else if (!issue && out_dec)
            out_d = out_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            fifo_cnd_q <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q      <= occ_d;
            fifo_cnd_q <= {occ_q == CW'(DEPTH), occ_q >= CW'(DEPTH / 2)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= stream_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            key_sh_q     <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            blk_cnt_q    <= '0;
            out_q        <= '0;
            rekey_q      <= 1'b0;
            seen02_q     <= 1'b0;
            err_q        <= 1'b0;
            key_q        <= 1'b0;
            strob_key_q  <= 1'b0;
            data_q       <= '0;
            strob_data_q <= 1'b0;
        end else begin
            strob_data_q <= issue;
            if (issue) begin
                data_q    <= tx_data_i;
                blk_cnt_q <= blk_cnt_q + 9'd1;
            end
            out_q <= out_d;

            case (state_q)
                S_IDLE: begin
                    if (key_load_i) begin
                        key_sh_q    <= key_in_i;
                        err_q       <= 1'b0;
                        state_q     <= S_SHIFT;
                        bit_cnt_q   <= '0;
                        strob_key_q <= 1'b1;
                        key_q       <= key_in_i[79];
                        blk_cnt_q   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q == 7'd79) begin
                        state_q     <= S_WAIT_RUN;
                        strob_key_q <= 1'b0;
                        key_q       <= 1'b0;
                        timer_q     <= 12'(WAIT_MAX);
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 7'd1;
                        key_sh_q  <= {key_sh_q[78:0], 1'b0};
                        key_q     <= key_sh_q[78];
                    end
                end
                S_WAIT_RUN: begin
                    if (sign_reg_i == 8'h01) begin
                        state_q <= S_RUN;
                    end else if (timer_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - 12'd1;
                    end
                end
                S_RUN, S_WAIT_BLK: begin
                    // A pending rekey waits for every in-flight byte to come back first.
                    if (rekey_q) begin
                        if (out_q == '0) begin
                            state_q     <= S_SHIFT;
                            bit_cnt_q   <= '0;
                            strob_key_q <= 1'b1;
                            key_q       <= key_sh_q[79];
                            blk_cnt_q   <= '0;
                            rekey_q     <= 1'b0;
                        end
                    end else if (key_load_i) begin
                        key_sh_q <= key_in_i;
                        rekey_q  <= 1'b1;
                        err_q    <= 1'b0;
                    end else if (state_q == S_RUN) begin
                        if (issue && (blk_cnt_q == 9'd255)) begin
                            state_q  <= S_WAIT_BLK;
                            seen02_q <= 1'b0;
                            timer_q  <= 12'(WAIT_MAX);
                        end
                    end else if (seen02_q && (sign_reg_i == 8'h01)) begin
                        state_q   <= S_RUN;
                        blk_cnt_q <= '0;
                    end else if (timer_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - 12'd1;
                        if (sign_reg_i == 8'h02)
                            seen02_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (wt_sgn_i && fifo_full)
                err_q <= 1'b1;

            if (core_fault) begin
                state_q     <= S_IDLE;
                err_q       <= 1'b1;
                out_q       <= '0;
                blk_cnt_q   <= '0;
                strob_key_q <= 1'b0;
                key_q       <= 1'b0;
                rekey_q     <= 1'b0;
            end
        end
    end

    assign tx_ready_o   = issue;
    assign rx_valid_o   = (occ_q != '0);
    assign rx_data_o    = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign key_o        = key_q;
    assign strob_key_o  = strob_key_q;
    assign data_o       = data_q;
    assign strob_data_o = strob_data_q;
    assign fifo_cnd_o   = fifo_cnd_q;
    assign busy_o       = (state_q != S_IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_trivium_feeder.sv
// Directed bench for trivium_feeder with a 2-cycle XOR-A5 echo model of the core.
module tb_trivium_feeder;
    localparam int WAIT_MAX = 2047;
    localparam logic [79:0] K1 = 80'h8000_0000_0000_0000_0001;
    localparam logic [79:0] K2 = 80'h0123_4567_89AB_CDEF_FEDC;
    localparam logic [7:0] EXP_ENC [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key_in;
    logic        key_load;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        key;
    logic        strob_key;
    logic [7:0]  data;
    logic        strob_data;
    logic [1:0]  fifo_cnd;
    logic [7:0]  stream;
    logic        wt_sgn;
    logic [7:0]  sign_reg;
    logic        busy;
    logic        err;

    logic        p1_v;
    logic [7:0]  p1_d;

    int checks = 0;
    int failures = 0;
    int sent, nstrob, nsk, bad, cnd_last;
    logic [7:0]  rxq [$];
    logic [1:0]  cndq [$];
    logic [79:0] got;

    always #5 clk = ~clk;

    trivium_feeder #(.DEPTH(8), .WAIT_MAX(WAIT_MAX)) dut (
        .clk_i(clk), .rst_i(rst), .key_in_i(key_in), .key_load_i(key_load),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .key_o(key), .strob_key_o(strob_key), .data_o(data), .strob_data_o(strob_data),
        .fifo_cnd_o(fifo_cnd), .stream_i(stream), .wt_sgn_i(wt_sgn),
        .sign_reg_i(sign_reg), .busy_o(busy), .err_o(err)
    );

    // Core echo: ciphertext = plaintext ^ A5, returned two cycles after strob_data.
    always @(posedge clk) begin
        if (rst) begin
            p1_v   <= 1'b0;
            p1_d   <= 8'h00;
            wt_sgn <= 1'b0;
            stream <= 8'h00;
        end else begin
            p1_v   <= strob_data;
            p1_d   <= data ^ 8'hA5;
            wt_sgn <= p1_v;
            stream <= p1_d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_stream(input int n_offer, input logic [7:0] base, input logic rdy, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            tx_valid = (sent < n_offer);
            tx_data  = base + 8'(sent);
            rx_ready = rdy;
            #1;
            if (tx_ready) sent++;
            if (strob_data) nstrob++;
            if (rx_valid && rx_ready) rxq.push_back(rx_data);
            if (int'(fifo_cnd) != cnd_last) begin
                cndq.push_back(fifo_cnd);
                cnd_last = int'(fifo_cnd);
            end
            tick();
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_in = '0; key_load = 1'b0; tx_data = '0; tx_valid = 1'b0;
        rx_ready = 1'b0; sign_reg = 8'h00; cnd_last = -1;
        repeat (3) tick();

        chk("rst_tx_ready",   80'(tx_ready),   80'd0);
        chk("rst_rx_valid",   80'(rx_valid),   80'd0);
        chk("rst_rx_data",    80'(rx_data),    80'd0);
        chk("rst_strob_key",  80'(strob_key),  80'd0);
        chk("rst_key",        80'(key),        80'd0);
        chk("rst_strob_data", 80'(strob_data), 80'd0);
        chk("rst_fifo_cnd",   80'(fifo_cnd),   80'd0);
        chk("rst_busy",       80'(busy),       80'd0);
        chk("rst_err",        80'(err),        80'd0);

        // Key shift: strob_key for t+1..t+80, MSB first
        rst = 1'b0; key_in = K1; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        nsk = 0; got = '0;
        for (int i = 0; i < 80; i++) begin
            got[79-i] = key;
            if (strob_key) nsk++;
            tick();
        end
        chk("shift_cycles", 80'(nsk), 80'd80);
        chk("shift_bits", got, K1);
        chk("shift_done_strob", 80'(strob_key), 80'd0);
        chk("shift_busy", 80'(busy), 80'd1);

        // Core reports running 1152 cycles after key_load
        repeat (1071) tick();
        sign_reg = 8'h01;
        tick();

        // Byte encryption: 00..07 back-to-back, host always ready
        sent = 0; nstrob = 0; rxq.delete();
        run_stream(8, 8'h00, 1'b1, 20);
        chk("enc_sent", 80'(sent), 80'd8);
        chk("enc_strobes", 80'(nstrob), 80'd8);
        chk("enc_rx_count", 80'(rxq.size()), 80'd8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= rxq.size() || rxq[i] !== EXP_ENC[i]) bad++;
        chk("enc_rx_values", 80'(bad), 80'd0);
        chk("enc_err", 80'(err), 80'd0);

        // Back-pressure: host stalled, only DEPTH bytes may go out
        sent = 0; nstrob = 0; rxq.delete(); cndq.delete(); cnd_last = -1;
        run_stream(20, 8'h10, 1'b0, 30);
        chk("bp_sent", 80'(sent), 80'd8);
        chk("bp_strobes", 80'(nstrob), 80'd8);
        chk("bp_cnd_steps", 80'(cndq.size()), 80'd3);
        chk("bp_cnd_seq", 80'({cndq[0], cndq[1], cndq[2]}), 80'({2'b00, 2'b01, 2'b11}));
        tx_valid = 1'b1; #1;
        chk("bp_tx_ready_held", 80'(tx_ready), 80'd0);
        chk("bp_rx_valid", 80'(rx_valid), 80'd1);
        tx_valid = 1'b0;
        tick();

        run_stream(20, 8'h10, 1'b1, 40);
        chk("bp_resume_sent", 80'(sent), 80'd20);
        chk("bp_rx_count", 80'(rxq.size()), 80'd20);
        bad = 0;
        foreach (rxq[i]) if (rxq[i] !== ((8'h10 + 8'(i)) ^ 8'hA5)) bad++;
        chk("bp_rx_values", 80'(bad), 80'd0);
        chk("bp_err", 80'(err), 80'd0);

        // Rekey from RUN: new key shifted once in-flight count is zero
        key_in = K2; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        for (int w = 0; w < 10 && !strob_key; w++) tick();
        nsk = 0; got = '0;
        for (int i = 0; i < 80; i++) begin
            got[79-i] = key;
            if (strob_key) nsk++;
            tick();
        end
        chk("rekey_cycles", 80'(nsk), 80'd80);
        chk("rekey_bits", got, K2);
        chk("rekey_strob_off", 80'(strob_key), 80'd0);
        repeat (2) tick();

        // Block boundary: 300 offered, stop at 256, resume after 02 then 01
        sent = 0; nstrob = 0; rxq.delete();
        run_stream(300, 8'h00, 1'b1, 280);
        chk("blk_stop", 80'(sent), 80'd256);
        run_stream(300, 8'h00, 1'b1, 10);
        chk("blk_hold_on_01", 80'(sent), 80'd256);
        chk("blk_busy", 80'(busy), 80'd1);
        sign_reg = 8'h02;
        run_stream(300, 8'h00, 1'b1, 3);
        chk("blk_hold_on_02", 80'(sent), 80'd256);
        sign_reg = 8'h01;
        run_stream(300, 8'h00, 1'b1, 70);
        chk("blk_total_sent", 80'(sent), 80'd300);
        chk("blk_strobes", 80'(nstrob), 80'd300);
        chk("blk_rx_count", 80'(rxq.size()), 80'd300);
        bad = 0;
        foreach (rxq[i]) if (rxq[i] !== (8'(i) ^ 8'hA5)) bad++;
        chk("blk_rx_values", 80'(bad), 80'd0);
        chk("blk_err", 80'(err), 80'd0);

        // Core error during RUN
        sign_reg = 8'h04;
        tick();
        chk("coreerr_err", 80'(err), 80'd1);
        chk("coreerr_busy", 80'(busy), 80'd0);
        sign_reg = 8'h00;
        tick();

        // Timeout: status never 01
        key_in = K1; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("to_err_cleared", 80'(err), 80'd0);
        chk("to_busy_start", 80'(busy), 80'd1);
        repeat (80 + WAIT_MAX) tick();
        chk("to_busy_before", 80'(busy), 80'd1);
        chk("to_err_before", 80'(err), 80'd0);
        tick();
        chk("to_busy_after", 80'(busy), 80'd0);
        chk("to_err_after", 80'(err), 80'd1);

        // Reset in the middle of a key shift
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (40) tick();
        chk("midshift_strob", 80'(strob_key), 80'd1);
        rst = 1'b1;
        tick();
        chk("rst2_strob_key",  80'(strob_key),  80'd0);
        chk("rst2_key",        80'(key),        80'd0);
        chk("rst2_busy",       80'(busy),       80'd0);
        chk("rst2_err",        80'(err),        80'd0);
        chk("rst2_tx_ready",   80'(tx_ready),   80'd0);
        chk("rst2_rx_valid",   80'(rx_valid),   80'd0);
        chk("rst2_data",       80'(data),       80'd0);
        chk("rst2_strob_data", 80'(strob_data), 80'd0);
        chk("rst2_fifo_cnd",   80'(fifo_cnd),   80'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_strob", 80'(strob_key), 80'd0);
        chk("post_rst_busy", 80'(busy), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
